// File: rtl/herring_bus_responder_if.sv
// 6502-side bus bundle for the 0x8C00 responder: phi2, select, RWB,
// A3..A0, data in/out, transceiver enable and the interrupt line.
interface herring_bus_responder_if;
    logic       cpu_clk_out;
    logic       cs_n;
    logic       rw;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       irq_n;

    // responder end (inside the FPGA)
    modport slave (
        input  cpu_clk_out, cs_n, rw, address, data_in,
        output data_out, data_oe, irq_n
    );

    // CPU / bus-model end
    modport master (
        output cpu_clk_out, cs_n, rw, address, data_in,
        input  data_out, data_oe, irq_n
    );
endinterface

// File: rtl/herring_bus_responder.sv
// CPU-bus responder for the 0x8C00 chip select. phi2 is oversampled on
// clk_src; bus fields are delayed to line up with the synchronized phi2 so
// every commit uses the bus state seen at the last phi2-high sample.
// Holds ID/SCRATCH/CTRL/STATUS and a 16-bit prescaled down-timer with IRQ.
module herring_bus_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'h48
) (
    input  logic                   clk_src,
    input  logic                   rst_n,
    herring_bus_responder_if.slave bus
);

    typedef struct packed {
        logic       cs_n;
        logic       rw;
        logic [3:0] address;
        logic [7:0] data_in;
    } bus_req_t;

    localparam bus_req_t REQ_IDLE = '{cs_n: 1'b1, rw: 1'b1, address: 4'h0, data_in: 8'h00};

    logic [SYNC_STAGES-1:0] p_sync;
    logic                   p_s, p_d, rise, fall;
    bus_req_t               req_pipe [0:SYNC_STAGES];
    bus_req_t               al;

    logic [7:0]  scratch, prescale, pre_cnt, rd_mux;
    logic        en, irq_en, auto_rl, tf, irq_q;
    logic [15:0] reload, count, snapshot;
    logic        wr_en, snap_en, tick, expire, tf_clr;

    assign p_s  = p_sync[SYNC_STAGES-1];
    assign rise = p_s & ~p_d;
    assign fall = ~p_s & p_d;
    assign al   = req_pipe[SYNC_STAGES];

    // phi2 synchronizer plus one-cycle history for edge detection
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            p_sync <= '0;
            p_d    <= 1'b0;
        end else begin
            p_sync[0] <= bus.cpu_clk_out;
            for (int i = 1; i < SYNC_STAGES; i++) p_sync[i] <= p_sync[i-1];
            p_d <= p_s;
        end
    end

    // bus sample pipeline; oldest entry shares its sample edge with p_d
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) req_pipe[i] <= REQ_IDLE;
        end else begin
            req_pipe[0] <= '{cs_n: bus.cs_n, rw: bus.rw, address: bus.address, data_in: bus.data_in};
            for (int i = 1; i <= SYNC_STAGES; i++) req_pipe[i] <= req_pipe[i-1];
        end
    end

    // bus event and timer tick decode
    always_comb begin
        wr_en   = fall & ~al.cs_n & ~al.rw;
        snap_en = rise & ~al.cs_n & al.rw & (al.address == 4'd6);
        // STATUS read, or STATUS write with bit0 set
        tf_clr  = fall & ~al.cs_n & (al.address == 4'd3) & (al.rw | al.data_in[0]);
        tick    = en & (pre_cnt == prescale);
        expire  = tick & (count == 16'd0);
    end

    // prescaler: counts 0..PRESCALE while enabled, parked at 0 otherwise
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n)     pre_cnt <= 8'h00;
        else if (!en)   pre_cnt <= 8'h00;
        else if (tick)  pre_cnt <= 8'h00;
        else            pre_cnt <= pre_cnt + 8'd1;
    end

    // register file and timer; CPU writes come last so they override the
    // timer's own updates of EN and COUNT in the same cycle
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            scratch  <= 8'h00;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            auto_rl  <= 1'b0;
            tf       <= 1'b0;
            reload   <= 16'h0000;
            count    <= 16'h0000;
            prescale <= 8'h00;
            snapshot <= 16'h0000;
        end else begin
            if (tick) begin
                if (count != 16'd0) count <= count - 16'd1;
                else if (auto_rl)   count <= reload;
                else                en    <= 1'b0;
            end
            // a set in the same cycle as a clear leaves TF set
            if (expire)      tf <= 1'b1;
            else if (tf_clr) tf <= 1'b0;
            if (snap_en) snapshot <= count;
            if (wr_en) begin
                case (al.address)
                    4'd1: scratch <= al.data_in;
                    4'd2: {auto_rl, irq_en, en} <= al.data_in[2:0];
                    4'd4: reload[7:0] <= al.data_in;
                    4'd5: begin
                        reload[15:8] <= al.data_in;
                        count        <= {al.data_in, reload[7:0]};
                    end
                    4'd8: prescale <= al.data_in;
                    default: ;
                endcase
            end
        end
    end

    // registered interrupt output
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b1;
        else        irq_q <= ~(tf & irq_en);
    end

    // read mux on the live address so data is valid within the phi2-high phase
    always_comb begin
        rd_mux = 8'h00;
        case (bus.address)
            4'd0: rd_mux = ID_VALUE;
            4'd1: rd_mux = scratch;
            4'd2: rd_mux = {5'b0, auto_rl, irq_en, en};
            4'd3: rd_mux = {7'b0, tf};
            4'd4: rd_mux = reload[7:0];
            4'd5: rd_mux = reload[15:8];
            4'd6: rd_mux = snapshot[7:0];
            4'd7: rd_mux = snapshot[15:8];
            4'd8: rd_mux = prescale;
            default: rd_mux = 8'h00;
        endcase
    end

    assign bus.data_out = rst_n ? rd_mux : 8'h00;
    assign bus.data_oe  = bus.cpu_clk_out & ~bus.cs_n & bus.rw & rst_n;
    assign bus.irq_n    = irq_q;

endmodule

// File: tb/tb_herring_bus_responder.sv
// Bench for herring_bus_responder: 1 MHz 6502 bus model on a 50 MHz clock,
// directed register/timer steps plus a randomized register phase checked
// against a small register model kept here.
module tb_herring_bus_responder;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_rise_cyc = 0;
    int   last_fall_cyc = 0;
    int   irq_fall_cyc = -1;
    logic irq_prev = 1'b1;

    herring_bus_responder_if bus();

    herring_bus_responder #(.SYNC_STAGES(SYNC), .ID_VALUE(8'h48)) dut (
        .clk_src (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // remember the clock index at which irq_n last went low
    always @(negedge clk) begin
        irq_prev <= bus.irq_n;
        if (irq_prev && !bus.irq_n) irq_fall_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 1 us phi2 cycle: 250 ns phase-1 setup, 500 ns phi2 high, then
    // data/select change 15 ns after the fall. Optional reset pulse during
    // phi2 high, released 100 ns after the fall.
    task automatic bus_cycle(input logic csn, input logic rd, input logic [3:0] a,
                             input logic [7:0] wd, input bit do_rst,
                             output logic [7:0] rdat, output logic oe_hi, output logic oe_lo);
        bus.cs_n    = csn;
        bus.rw      = rd;
        bus.address = a;
        bus.data_in = rd ? 8'($urandom) : wd;
        #200 oe_lo = bus.data_oe;
        #50  bus.cpu_clk_out = 1'b1;
        last_rise_cyc = cyc;
        #400 rdat  = bus.data_out;
        oe_hi = bus.data_oe;
        if (do_rst) begin
            rst_n = 1'b0;
            #20;
            chk("rst_data_oe", bus.data_oe, 0);
            chk("rst_data_out", bus.data_out, 0);
            chk("rst_irq_n", bus.irq_n, 1);
            #80;
        end else begin
            #100;
        end
        bus.cpu_clk_out = 1'b0;
        last_fall_cyc = cyc;
        #15 bus.data_in = 8'($urandom);
        bus.cs_n = 1'b1;
        bus.rw   = 1'b1;
        if (do_rst) begin
            #85 rst_n = 1'b1;
            #150;
        end else begin
            #235;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic oh, ol;
        bus_cycle(1'b0, 1'b0, a, d, 1'b0, r, oh, ol);
        chk("wr_data_oe", {oh, ol}, 0);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        logic oh, ol;
        bus_cycle(1'b0, 1'b1, a, 8'h00, 1'b0, d, oh, ol);
        chk("rd_data_oe", {oh, ol}, 2'b10);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // bounded wait for a new irq_n fall; returns its clock index
    task automatic wait_irq(input int prev, output int got);
        int n = 0;
        while (irq_fall_cyc == prev && n < 200) begin
            #10;
            n++;
        end
        got = irq_fall_cyc;
        chk("irq_fell", (irq_fall_cyc != prev), 1);
    endtask

    // Timing model: a phi2 edge first seen at clock index c+1 takes effect
    // (commit or snapshot) at clock index c+1+SYNC.
    function automatic int eff_edge(input int c);
        return c + 1 + SYNC;
    endfunction

    logic [7:0] m_scratch, m_rlo, m_pre, d, dl, dh;
    logic       oh, ol;
    int         prev, got, c, r, cm;
    logic [15:0] snap_exp;

    initial begin
        m_scratch = 8'h00; m_rlo = 8'h00; m_pre = 8'h00;
        // reset held with a CPU read in progress
        bus.cpu_clk_out = 1'b1; bus.cs_n = 1'b0; bus.rw = 1'b1;
        bus.address = 4'h0; bus.data_in = 8'h00;
        #53;
        chk("reset_data_oe", bus.data_oe, 0);
        chk("reset_data_out", bus.data_out, 0);
        chk("reset_irq_n", bus.irq_n, 1);
        bus.cpu_clk_out = 1'b0; bus.cs_n = 1'b1;
        #100 rst_n = 1'b1;
        #100;

        rd_chk("id", 4'd0, 8'h48);
        rd_chk("scratch_rst", 4'd1, 8'h00);
        rd_chk("off15", 4'd15, 8'h00);
        rd_chk("ctrl_rst", 4'd2, 8'h00);
        rd_chk("status_rst", 4'd3, 8'h00);

        // SCRATCH write/readback; unselected write ignored; data_in changes
        // 15 ns after each fall inside bus_cycle
        wr(4'd1, 8'hA5);
        m_scratch = 8'hA5;
        rd_chk("scratch_wr", 4'd1, 8'hA5);
        bus_cycle(1'b1, 1'b0, 4'd1, 8'h3C, 1'b0, d, oh, ol);
        chk("unsel_oe", {oh, ol}, 0);
        rd_chk("scratch_unsel", 4'd1, 8'hA5);

        // randomized register traffic against the model (timer regs excluded)
        for (int i = 0; i < 24; i++) begin
            logic [3:0] a;
            logic       rdn, csn;
            logic [7:0] wd, exp;
            a   = 4'($urandom_range(0, 15));
            if (a inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd7}) a = 4'd1;
            rdn = 1'($urandom_range(0, 1));
            csn = ($urandom_range(0, 3) == 0);
            wd  = 8'($urandom);
            case (a)
                4'd0:    exp = 8'h48;
                4'd1:    exp = m_scratch;
                4'd4:    exp = m_rlo;
                4'd8:    exp = m_pre;
                default: exp = 8'h00;
            endcase
            bus_cycle(csn, rdn, a, wd, 1'b0, d, oh, ol);
            chk("rnd_oe", {oh, ol}, {(~csn & rdn), 1'b0});
            if (!csn && rdn) chk("rnd_read", d, exp);
            if (!csn && !rdn) begin
                if (a == 4'd1) m_scratch = wd;
                if (a == 4'd4) m_rlo = wd;
                if (a == 4'd8) m_pre = wd;
            end
        end
        rd_chk("rnd_scratch", 4'd1, m_scratch);
        rd_chk("rnd_rlo", 4'd4, m_rlo);
        rd_chk("rnd_pre", 4'd8, m_pre);

        // auto-reload: PRESCALE=0, RELOAD=3 -> TF after (0+1)*(3+1) ticks
        wr(4'd8, 8'd0); wr(4'd4, 8'd3); wr(4'd5, 8'd0);
        prev = irq_fall_cyc;
        wr(4'd2, 8'h07);
        cm = eff_edge(last_fall_cyc);
        wait_irq(prev, got);
        chk("irq_lat_ar", got, cm + 1 * 4 + 1);
        rd(4'd6, dl);
        chk("ar_cnt_le3", (dl <= 8'd3), 1);
        rd_chk("ar_cnt_hi", 4'd7, 8'h00);
        rd_chk("ar_status", 4'd3, 8'h01);
        wr(4'd2, 8'h06);
        rd_chk("ar_status2", 4'd3, 8'h01);
        chk("ar_irq_clr", bus.irq_n, 1);
        rd_chk("ar_status3", 4'd3, 8'h00);
        rd_chk("ar_ctrl", 4'd2, 8'h06);

        // one-shot: PRESCALE=4, RELOAD=2 -> expiry 5*3 = 15 clocks after enable
        wr(4'd8, 8'd4); wr(4'd4, 8'd2); wr(4'd5, 8'd0);
        prev = irq_fall_cyc;
        wr(4'd2, 8'h03);
        cm = eff_edge(last_fall_cyc);
        wait_irq(prev, got);
        chk("irq_lat_os", got, cm + 5 * 3 + 1);
        rd_chk("os_ctrl", 4'd2, 8'h02);
        rd_chk("os_cnt_lo", 4'd6, 8'h00);
        rd_chk("os_cnt_hi", 4'd7, 8'h00);
        rd_chk("os_status", 4'd3, 8'h01);
        chk("os_irq_clr", bus.irq_n, 1);

        // snapshot coherence across 0x00FF; RELOAD_HI load lands on a tick
        wr(4'd8, 8'd0); wr(4'd4, 8'h20); wr(4'd2, 8'h05);
        wr(4'd5, 8'h01);
        c = last_fall_cyc;
        rd(4'd6, dl);
        r = last_rise_cyc;
        rd(4'd7, dh);
        // COUNT after clock e is 0x0120 - (e - commit); snapshot holds the
        // value just before its own capture edge
        snap_exp = 16'(32'h0120 - ((eff_edge(r) - 1) - eff_edge(c)));
        chk("snap_lo", dl, snap_exp[7:0]);
        chk("snap_hi", dh, snap_exp[15:8]);
        wr(4'd2, 8'h00);
        rd_chk("snap_status", 4'd3, 8'h01);

        // bus cycles are exactly 50 clocks apart: RELOAD=48 expires one clock
        // before the next W1C commit, RELOAD=49 on the same clock
        wr(4'd4, 8'd48); wr(4'd5, 8'd0);
        wr(4'd2, 8'h03);
        wr(4'd3, 8'h01);
        chk("w1c_before_irq", bus.irq_n, 1);
        rd_chk("w1c_before", 4'd3, 8'h00);
        wr(4'd4, 8'd49); wr(4'd5, 8'd0);
        wr(4'd2, 8'h03);
        wr(4'd3, 8'h01);
        chk("w1c_same_irq", bus.irq_n, 0);
        rd_chk("w1c_same", 4'd3, 8'h01);

        // reset in the middle of a read, and during a write whose fall is in reset
        wr(4'd1, 8'h77);
        wr(4'd4, 8'd3); wr(4'd5, 8'd0); wr(4'd2, 8'h07);
        chk("pre_rst_irq", bus.irq_n, 0);
        bus_cycle(1'b0, 1'b1, 4'd1, 8'h00, 1'b1, d, oh, ol);
        chk("pre_rst_read", d, 8'h77);
        rd_chk("post_rst_scratch", 4'd1, 8'h00);
        rd_chk("post_rst_ctrl", 4'd2, 8'h00);
        bus_cycle(1'b0, 1'b0, 4'd1, 8'h5A, 1'b1, d, oh, ol);
        rd_chk("rst_write_dropped", 4'd1, 8'h00);
        chk("post_rst_irq", bus.irq_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
